// File: rtl/adder_arbiter_if.sv
// adder_arbiter_if: bundles the two requester channels, the response channel
// and the status outputs of adder_arbiter.
//
// Handshake rule shared by every channel: a transfer happens on a rising
// clock edge where valid and ready are both high. A source holds its payload
// stable while valid is high and ready is low. Requesters must not make
// reqN_valid depend on reqN_ready, because ready is derived combinationally
// from the valids.
interface adder_arbiter_if #(
    parameter int WIDTH = 32
);
    // Requester 0
    logic             req0_valid;
    logic             req0_ready;
    logic [WIDTH-1:0] req0_a;
    logic [WIDTH-1:0] req0_b;
    logic             req0_cin;
    logic             req0_sub;

    // Requester 1
    logic             req1_valid;
    logic             req1_ready;
    logic [WIDTH-1:0] req1_a;
    logic [WIDTH-1:0] req1_b;
    logic             req1_cin;
    logic             req1_sub;

    // Response channel
    logic             rsp_valid;
    logic             rsp_ready;
    logic             rsp_id;
    logic [WIDTH-1:0] rsp_sum;
    logic             rsp_cout;
    logic             rsp_overflow;

    // Status and debug visibility of the controller FSM
    logic             busy;
    logic [1:0]       dbg_state;

    // Requesters plus response consumer
    modport master (
        output req0_valid, req0_a, req0_b, req0_cin, req0_sub,
        output req1_valid, req1_a, req1_b, req1_cin, req1_sub,
        output rsp_ready,
        input  req0_ready, req1_ready,
        input  rsp_valid, rsp_id, rsp_sum, rsp_cout, rsp_overflow,
        input  busy, dbg_state
    );

    // The arbiter itself
    modport slave (
        input  req0_valid, req0_a, req0_b, req0_cin, req0_sub,
        input  req1_valid, req1_a, req1_b, req1_cin, req1_sub,
        input  rsp_ready,
        output req0_ready, req1_ready,
        output rsp_valid, rsp_id, rsp_sum, rsp_cout, rsp_overflow,
        output busy, dbg_state
    );
endinterface

// File: rtl/adder_arbiter.sv
// adder_arbiter: shares one ripple_carry adder between two requesters.
// Round-robin arbitration in IDLE, operands held in registers for
// SETTLE_CYCLES cycles while the ripple path resolves, then sum, carry-out
// and signed overflow are captured into a valid/ready response register.
//
// Optional feature macro: ADDER_ARB_SUB_EN. When defined, reqN_sub selects
// subtraction (b inverted, carry-in forced to 1). When undefined, reqN_sub is
// ignored and the b/cin path carries no inverter or mux.
//
// SETTLE_CYCLES must lie in 1..15 (4-bit settle counter).

// Plain 32-bit ripple-carry adder; the long carry chain is the reason the
// arbiter holds its operands for several cycles before sampling the result.
module ripple_carry #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);
    logic carry;

    // Bit-serial carry propagation from LSB to MSB
    always_comb begin
        sum   = '0;
        carry = cin;
        for (int i = 0; i < WIDTH; i++) begin
            sum[i] = a[i] ^ b[i] ^ carry;
            carry  = (a[i] & b[i]) | (carry & (a[i] ^ b[i]));
        end
        cout = carry;
    end
endmodule

module adder_arbiter #(
    parameter int WIDTH         = 32,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic            clk,
    input  logic            rst,
    adder_arbiter_if.slave  bus
);
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        RESP   = 2'd2
    } state_t;

    localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);

    state_t           state;
    state_t           state_next;
    logic             busy_q;
    logic             last_grant;
    logic [3:0]       settle_cnt;

    // Operand registers feeding the shared adder
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             op_cin;
    logic             op_id;

    // Response register
    logic             rsp_valid_q;
    logic             rsp_id_q;
    logic [WIDTH-1:0] rsp_sum_q;
    logic             rsp_cout_q;
    logic             rsp_ovf_q;

    logic             grant0;
    logic             grant1;
    logic             ready0;
    logic             ready1;
    logic             accept;
    logic             capture;
    logic             rsp_fire;

    logic [WIDTH-1:0] eff_b0;
    logic [WIDTH-1:0] eff_b1;
    logic             eff_cin0;
    logic             eff_cin1;

    logic [WIDTH-1:0] add_sum;
    logic             add_cout;
    logic             add_ovf;

`ifdef ADDER_ARB_SUB_EN
    // Subtraction as a + ~b + 1; sub overrides the requester's carry-in
    always_comb begin
        eff_b0   = bus.req0_sub ? ~bus.req0_b : bus.req0_b;
        eff_cin0 = bus.req0_sub ? 1'b1 : bus.req0_cin;
        eff_b1   = bus.req1_sub ? ~bus.req1_b : bus.req1_b;
        eff_cin1 = bus.req1_sub ? 1'b1 : bus.req1_cin;
    end
`else
    logic unused_sub;

    // Add-only build: operands pass straight through, sub bits are ignored
    always_comb begin
        eff_b0   = bus.req0_b;
        eff_cin0 = bus.req0_cin;
        eff_b1   = bus.req1_b;
        eff_cin1 = bus.req1_cin;
    end

    assign unused_sub = bus.req0_sub ^ bus.req1_sub;
`endif

    // Round-robin: a lone request wins; on a tie the side not granted last wins
    always_comb begin
        grant0 = bus.req0_valid && (!bus.req1_valid || last_grant);
        grant1 = bus.req1_valid && (!bus.req0_valid || !last_grant);
    end

    // Readies only in IDLE, and forced low while reset is asserted
    assign ready0   = (state == IDLE) && grant0 && !rst;
    assign ready1   = (state == IDLE) && grant1 && !rst;
    assign accept   = ready0 || ready1;
    assign capture  = (state == SETTLE) && (settle_cnt == 4'd0);
    assign rsp_fire = rsp_valid_q && bus.rsp_ready;

    ripple_carry #(
        .WIDTH(WIDTH)
    ) u_adder (
        .a   (op_a),
        .b   (op_b),
        .cin (op_cin),
        .sum (add_sum),
        .cout(add_cout)
    );

    // Signed overflow: both operands share a sign that the sum does not
    assign add_ovf = (op_a[WIDTH-1] & op_b[WIDTH-1] & ~add_sum[WIDTH-1]) |
                     (~op_a[WIDTH-1] & ~op_b[WIDTH-1] & add_sum[WIDTH-1]);

    // Next-state logic for IDLE -> SETTLE -> RESP -> IDLE
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept)   state_next = SETTLE;
            SETTLE:  if (capture)  state_next = RESP;
            RESP:    if (rsp_fire) state_next = IDLE;
            default:               state_next = IDLE;
        endcase
    end

    // State register; busy is registered alongside so it tracks state != IDLE
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            busy_q <= 1'b0;
        end else begin
            state  <= state_next;
            busy_q <= (state_next != IDLE);
        end
    end

    // Arbitration history and settle countdown
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_grant <= 1'b1;
            settle_cnt <= 4'd0;
        end else if (accept) begin
            last_grant <= ready1;
            settle_cnt <= SETTLE_LOAD;
        end else if ((state == SETTLE) && (settle_cnt != 4'd0)) begin
            settle_cnt <= settle_cnt - 4'd1;
        end
    end

    // Operand latch: loaded only on acceptance, stable through SETTLE
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_a   <= '0;
            op_b   <= '0;
            op_cin <= 1'b0;
            op_id  <= 1'b0;
        end else if (accept) begin
            op_a   <= ready1 ? bus.req1_a : bus.req0_a;
            op_b   <= ready1 ? eff_b1     : eff_b0;
            op_cin <= ready1 ? eff_cin1   : eff_cin0;
            op_id  <= ready1;
        end
    end

    // Response register: captured at the end of SETTLE, held until consumed
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= 1'b0;
            rsp_sum_q   <= '0;
            rsp_cout_q  <= 1'b0;
            rsp_ovf_q   <= 1'b0;
        end else if (capture) begin
            rsp_valid_q <= 1'b1;
            rsp_id_q    <= op_id;
            rsp_sum_q   <= add_sum;
            rsp_cout_q  <= add_cout;
            rsp_ovf_q   <= add_ovf;
        end else if (rsp_fire) begin
            rsp_valid_q <= 1'b0;
        end
    end

    assign bus.req0_ready   = ready0;
    assign bus.req1_ready   = ready1;
    assign bus.rsp_valid    = rsp_valid_q;
    assign bus.rsp_id       = rsp_id_q;
    assign bus.rsp_sum      = rsp_sum_q;
    assign bus.rsp_cout     = rsp_cout_q;
    assign bus.rsp_overflow = rsp_ovf_q;
    assign bus.busy         = busy_q;
    assign bus.dbg_state    = state;
endmodule
